// File: rtl/qam_demapper_ctrl_if.sv
// qam_demapper_ctrl_if
// Bundles the frame-control, datapath and byte-read signals of the QAM
// demapper controller.
//   master : controller side (drives dp_load, data_out and status flags)
//   slave  : datapath/consumer side (drives enable, sym_valid, dp_data, read)
// Signals:
//   enable     frame enable level
//   sym_valid  I/Q symbol present at the datapath inputs
//   dp_load    load strobe to the datapath input registers
//   dp_data    demapped nibble returned by the datapath
//   read       consumer pop request
//   data_out   registered FIFO head byte, first symbol in [7:4]
//   available  FIFO non-empty
//   complete   frame fully delivered
//   overflow   sticky byte-dropped flag
//   busy       frame in progress (RUN or DRAIN)
interface qam_demapper_ctrl_if;
    logic       enable;
    logic       sym_valid;
    logic       dp_load;
    logic [3:0] dp_data;
    logic       read;
    logic [7:0] data_out;
    logic       available;
    logic       complete;
    logic       overflow;
    logic       busy;

    modport master (
        input  enable, sym_valid, dp_data, read,
        output dp_load, data_out, available, complete, overflow, busy
    );

    modport slave (
        output enable, sym_valid, dp_data, read,
        input  dp_load, data_out, available, complete, overflow, busy
    );
endinterface

// File: rtl/qam_demapper_ctrl.sv
// qam_demapper_ctrl
// Frame sequencer and output buffer for the QAM demapper datapath. Strobes
// the datapath once per accepted symbol, counts symbols per frame, packs the
// returned nibbles two per byte into a small FIFO and serves the bytes
// through a read handshake.
// Ports:
//   symbol_clock  single clock, rising edge
//   rst           asynchronous active-low reset
//   bus           qam_demapper_ctrl_if master modport (see interface file)
module qam_demapper_ctrl #(
    parameter int FRAME_SYMBOLS = 100,
    parameter int FIFO_DEPTH    = 8,
    parameter int DP_LATENCY    = 1
) (
    input  logic                symbol_clock,
    input  logic                rst,
    qam_demapper_ctrl_if.master bus
);
    localparam int CW = $clog2(FRAME_SYMBOLS + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] FRAME_LAST = CW'(FRAME_SYMBOLS);
    localparam logic [AW:0]   FIFO_FULL  = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       sym_cnt_q, sym_cnt_d;
    logic [DP_LATENCY-1:0] vpipe_q, vpipe_d;
    logic [3:0]          hi_q, hi_d;
    logic                half_full_q, half_full_d;
    logic [AW:0]         wr_ptr_q, wr_ptr_d;
    logic [AW:0]         rd_ptr_q, rd_ptr_d;
    logic [7:0]          data_out_q, data_out_d;
    logic                available_q, available_d;
    logic                complete_q, complete_d;
    logic                overflow_q, overflow_d;
    logic                busy_q, busy_d;

    logic [7:0]          fifo_mem [FIFO_DEPTH];
    logic [AW:0]         count;
    logic                full;
    logic                dp_load;
    logic                pipe_out;
    logic                pop;
    logic                push_req;
    logic                push_en;
    logic [7:0]          push_byte;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign count    = wr_ptr_q - rd_ptr_q;
    assign full     = (count == FIFO_FULL);
    assign dp_load  = bus.sym_valid && (state_q == RUN) && (sym_cnt_q < FRAME_LAST);
    assign pipe_out = vpipe_q[DP_LATENCY-1];
    // available_q always mirrors count != 0, so it is safe to gate pops with it.
    assign pop      = bus.read && available_q;

    always_comb begin
        state_d     = state_q;
        sym_cnt_d   = sym_cnt_q;
        hi_d        = hi_q;
        half_full_d = half_full_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        data_out_d  = data_out_q;
        overflow_d  = overflow_q;
        complete_d  = 1'b0;
        push_req    = 1'b0;
        push_byte   = 8'h00;

        // Valid pipe tracks which cycles carry a real nibble on dp_data.
        vpipe_d[0] = dp_load;
        for (int i = 1; i < DP_LATENCY; i++) begin
            vpipe_d[i] = vpipe_q[i-1];
        end

        if (dp_load) begin
            sym_cnt_d = sym_cnt_q + CW'(1);
        end

        // Nibble packer: first nibble waits in hi_q, second completes the byte.
        if (pipe_out) begin
            if (!half_full_q) begin
                hi_d        = bus.dp_data;
                half_full_d = 1'b1;
            end else begin
                push_req    = 1'b1;
                push_byte   = {hi_q, bus.dp_data};
                half_full_d = 1'b0;
            end
        end

        // Odd-length frame: flush the lone high nibble with a zero pad once
        // the pipe has emptied.
        if (state_q == DRAIN && vpipe_q == '0 && half_full_q) begin
            push_req    = 1'b1;
            push_byte   = {hi_q, 4'h0};
            half_full_d = 1'b0;
        end

        if (pop) begin
            data_out_d = fifo_mem[rd_ptr_q[AW-1:0]];
            rd_ptr_d   = rd_ptr_q + (AW + 1)'(1);
        end

        // A simultaneous pop frees the slot, so a push into a full FIFO is
        // only dropped when nothing leaves on the same edge.
        push_en = push_req && (!full || pop);
        if (push_req && full && !pop) begin
            overflow_d = 1'b1;
        end
        if (push_en) begin
            wr_ptr_d = wr_ptr_q + (AW + 1)'(1);
        end

        case (state_q)
            IDLE: begin
                if (bus.enable) begin
                    state_d     = RUN;
                    sym_cnt_d   = '0;
                    hi_d        = 4'h0;
                    half_full_d = 1'b0;
                    overflow_d  = 1'b0;
                    wr_ptr_d    = '0;
                    rd_ptr_d    = '0;
                end
            end
            RUN: begin
                if (sym_cnt_q == FRAME_LAST || !bus.enable) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (vpipe_q == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!bus.enable) begin
                    state_d = IDLE;
                end else begin
                    complete_d = (count == '0);
                end
            end
            default: state_d = IDLE;
        endcase

        available_d = ((wr_ptr_d - rd_ptr_d) != '0);
        busy_d      = (state_d == RUN) || (state_d == DRAIN);
    end

    always_ff @(posedge symbol_clock or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            sym_cnt_q   <= '0;
            vpipe_q     <= '0;
            hi_q        <= 4'h0;
            half_full_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            data_out_q  <= 8'h00;
            available_q <= 1'b0;
            complete_q  <= 1'b0;
            overflow_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sym_cnt_q   <= sym_cnt_d;
            vpipe_q     <= vpipe_d;
            hi_q        <= hi_d;
            half_full_q <= half_full_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            data_out_q  <= data_out_d;
            available_q <= available_d;
            complete_q  <= complete_d;
            overflow_q  <= overflow_d;
            busy_q      <= busy_d;
        end
    end

    // Storage needs no reset; only the pointers define what is valid.
    always_ff @(posedge symbol_clock) begin
        if (push_en) begin
            fifo_mem[wr_ptr_q[AW-1:0]] <= push_byte;
        end
    end

    assign bus.dp_load   = dp_load;
    assign bus.data_out  = data_out_q;
    assign bus.available = available_q;
    assign bus.complete  = complete_q;
    assign bus.overflow  = overflow_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_qam_demapper_ctrl.sv
// tb_qam_demapper_ctrl
// Directed bench for qam_demapper_ctrl. Two instances share one stimulus:
//   dut_a : FRAME_SYMBOLS=100, FIFO_DEPTH=8, DP_LATENCY=1
//   dut_b : FRAME_SYMBOLS=5,   FIFO_DEPTH=8, DP_LATENCY=2
// Each has a small datapath model returning the loaded symbol value after
// DP_LATENCY cycles, and a monitor collecting every popped byte.
module tb_qam_demapper_ctrl;
    logic       symbol_clock = 1'b0;
    logic       rst = 1'b0;
    logic       enable = 1'b0;
    logic       sym_valid = 1'b0;
    logic [3:0] sym_value = 4'h0;
    logic       read = 1'b0;

    int check_count = 0;
    int pass_count  = 0;

    logic [7:0] got_a[$];
    logic [7:0] got_b[$];
    logic [7:0] exp_q[$];

    qam_demapper_ctrl_if if_a ();
    qam_demapper_ctrl_if if_b ();

    always #5 symbol_clock = ~symbol_clock;

    assign if_a.enable    = enable;
    assign if_a.sym_valid = sym_valid;
    assign if_a.read      = read;
    assign if_b.enable    = enable;
    assign if_b.sym_valid = sym_valid;
    assign if_b.read      = read;

    // Datapath models: dp_data shows the symbol loaded DP_LATENCY cycles ago.
    logic [3:0] stage_a = 4'h0;
    logic [3:0] stage_b0 = 4'h0;
    logic [3:0] stage_b1 = 4'h0;
    always @(posedge symbol_clock) begin
        stage_a  <= sym_value;
        stage_b0 <= sym_value;
        stage_b1 <= stage_b0;
    end
    assign if_a.dp_data = stage_a;
    assign if_b.dp_data = stage_b1;

    qam_demapper_ctrl #(.FRAME_SYMBOLS(100), .FIFO_DEPTH(8), .DP_LATENCY(1)) dut_a (
        .symbol_clock (symbol_clock),
        .rst          (rst),
        .bus          (if_a.master)
    );

    qam_demapper_ctrl #(.FRAME_SYMBOLS(5), .FIFO_DEPTH(8), .DP_LATENCY(2)) dut_b (
        .symbol_clock (symbol_clock),
        .rst          (rst),
        .bus          (if_b.master)
    );

    // Pop monitors: decide at the falling edge whether a pop will happen,
    // then record data_out just after the rising edge.
    logic pend_a, pend_b;
    always begin
        @(negedge symbol_clock);
        pend_a = read && if_a.available;
        pend_b = read && if_b.available;
        @(posedge symbol_clock);
        #1;
        if (pend_a) got_a.push_back(if_a.data_out);
        if (pend_b) got_b.push_back(if_b.data_out);
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected finish");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_count++;
        if (got === exp) pass_count++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge symbol_clock);
        #2;
    endtask

    task automatic applyStimulus(input logic valid, input logic [3:0] value);
        sym_valid = valid;
        sym_value = value;
        step();
    endtask

    task automatic doReset();
        rst = 1'b0;
        enable = 1'b0;
        sym_valid = 1'b0;
        read = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
    endtask

    task automatic checkQueue(input bit sel, input string tag);
        int n;
        n = sel ? got_b.size() : got_a.size();
        checkOutput({tag, "_count"}, n, exp_q.size());
        for (int k = 0; k < n && k < exp_q.size(); k++) begin
            checkOutput($sformatf("%s[%0d]", tag, k), sel ? got_b[k] : got_a[k], exp_q[k]);
        end
    endtask

    task automatic waitComplete(input bit sel, input int budget, input string tag);
        logic c;
        c = sel ? if_b.complete : if_a.complete;
        for (int n = 0; n < budget && !c; n++) begin
            step();
            c = sel ? if_b.complete : if_a.complete;
        end
        checkOutput(tag, c, 1);
    endtask

    task automatic drainA(input int budget);
        read = 1'b1;
        for (int n = 0; n < budget && if_a.available; n++) step();
        read = 1'b0;
    endtask

    // Full 100-symbol frame on dut_a with read held high.
    task automatic runFullFrame(input string tag);
        logic [7:0] b;
        read = 1'b1;
        enable = 1'b1;
        step();
        checkOutput({tag, "_busy"}, if_a.busy, 1);
        got_a.delete();
        for (int i = 0; i < 100; i++) applyStimulus(1'b1, i[3:0]);
        #1;
        checkOutput({tag, "_load_at_cap"}, if_a.dp_load, 0);
        sym_valid = 1'b0;
        waitComplete(1'b0, 60, {tag, "_complete"});
        exp_q.delete();
        for (int k = 0; k < 50; k++) begin
            b = {k[2:0], 1'b0, k[2:0], 1'b1};
            exp_q.push_back(b);
        end
        checkQueue(1'b0, {tag, "_bytes"});
        checkOutput({tag, "_overflow"}, if_a.overflow, 0);
        checkOutput({tag, "_busy_end"}, if_a.busy, 0);
    endtask

    initial begin
        // Reset state
        doReset();
        checkOutput("rst_data_out", if_a.data_out, 8'h00);
        checkOutput("rst_available", if_a.available, 0);
        checkOutput("rst_complete", if_a.complete, 0);
        checkOutput("rst_overflow", if_a.overflow, 0);
        checkOutput("rst_busy", if_a.busy, 0);
        checkOutput("rst_dp_load", if_a.dp_load, 0);
        checkOutput("rst_b_busy", if_b.busy, 0);

        // Full frame, values i[3:0]
        runFullFrame("full");

        // Five-symbol frame with odd-length pad on dut_b
        doReset();
        read = 1'b1;
        enable = 1'b1;
        step();
        got_b.delete();
        applyStimulus(1'b1, 4'hA);
        applyStimulus(1'b1, 4'hB);
        applyStimulus(1'b1, 4'hC);
        applyStimulus(1'b1, 4'hD);
        applyStimulus(1'b1, 4'hE);
        sym_valid = 1'b0;
        waitComplete(1'b1, 30, "short_complete");
        exp_q = '{8'hAB, 8'hCD, 8'hE0};
        checkQueue(1'b1, "short_bytes");

        // Overflow: 20 symbols with read held low
        doReset();
        enable = 1'b1;
        step();
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, i[3:0]);
            if (i == 17) checkOutput("ovf_before_9th", if_a.overflow, 0);
            if (i == 18) checkOutput("ovf_at_9th", if_a.overflow, 1);
        end
        enable = 1'b0;
        applyStimulus(1'b0, 4'h0);
        enable = 1'b1;
        step();
        step();
        got_a.delete();
        drainA(20);
        exp_q = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};
        checkQueue(1'b0, "ovf_bytes");
        checkOutput("ovf_available", if_a.available, 0);
        checkOutput("ovf_sticky", if_a.overflow, 1);
        waitComplete(1'b0, 5, "ovf_complete");

        // Early enable drop on dut_b with two symbols in flight
        doReset();
        read = 1'b1;
        enable = 1'b1;
        step();
        got_b.delete();
        applyStimulus(1'b1, 4'h1);
        applyStimulus(1'b1, 4'h2);
        applyStimulus(1'b1, 4'h3);
        enable = 1'b0;
        applyStimulus(1'b0, 4'h0);
        enable = 1'b1;
        waitComplete(1'b1, 20, "early_complete");
        exp_q = '{8'h12, 8'h30};
        checkQueue(1'b1, "early_bytes");

        // Asynchronous reset mid-frame, then a clean full frame
        doReset();
        read = 1'b1;
        enable = 1'b1;
        step();
        for (int i = 0; i < 7; i++) applyStimulus(1'b1, i[3:0]);
        sym_valid = 1'b1;
        checkOutput("midrst_pre_data", if_a.data_out, 8'h23);
        checkOutput("midrst_pre_busy", if_a.busy, 1);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("midrst_data_out", if_a.data_out, 8'h00);
        checkOutput("midrst_available", if_a.available, 0);
        checkOutput("midrst_busy", if_a.busy, 0);
        checkOutput("midrst_dp_load", if_a.dp_load, 0);
        checkOutput("midrst_overflow", if_a.overflow, 0);
        checkOutput("midrst_complete", if_a.complete, 0);
        sym_valid = 1'b0;
        enable = 1'b0;
        read = 1'b0;
        step();
        rst = 1'b1;
        step();
        runFullFrame("refill");

        // Ignored read, then push and pop on the same edge while full
        doReset();
        enable = 1'b1;
        step();
        applyStimulus(1'b1, 4'h0);
        applyStimulus(1'b1, 4'h1);
        applyStimulus(1'b0, 4'h0);
        read = 1'b1;
        step();
        read = 1'b0;
        checkOutput("pop_data", if_a.data_out, 8'h01);
        checkOutput("pop_empty", if_a.available, 0);
        read = 1'b1;
        step();
        read = 1'b0;
        checkOutput("ignored_read", if_a.data_out, 8'h01);
        for (int v = 2; v < 18; v++) applyStimulus(1'b1, v[3:0]);
        applyStimulus(1'b1, 4'h2);
        applyStimulus(1'b1, 4'h3);
        sym_valid = 1'b0;
        read = 1'b1;
        step();
        read = 1'b0;
        checkOutput("full_pushpop_ovf", if_a.overflow, 0);
        checkOutput("full_pushpop_data", if_a.data_out, 8'h23);
        checkOutput("full_pushpop_avail", if_a.available, 1);
        got_a.delete();
        drainA(20);
        exp_q = '{8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF, 8'h01, 8'h23};
        checkQueue(1'b0, "full_drain");

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end
endmodule
